countdown_timer: RTL and testbench

//  Programmable down-counting timer with start/pause/reload control, one-shot or auto-reload mode,
//  a single-cycle done pulse and a sticky expired flag. Shared game-timing primitive: ghost mode

---
 rtl/countdown_timer.sv | 177 +++++++++++++++++
 tb/tb_countdown_timer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// countdown_timer
//
// Programmable down-counting timer shared by the game-timing logic (ghost mode phases,
// frightened duration, blink periods). The count is loaded from load_value, then counts down
// to zero once started. In one-shot mode it stops at zero and raises the sticky expired flag.
// In auto-reload mode it restarts from the reload value at the end of each period.
//
// Build option:
//   PRESCALE_EN  When defined, the count decrements once every TICK_DIV cycles spent in RUN.
//                When undefined, it decrements every cycle and no prescaler is built.
//
// Parameters:
//   MAX          Largest loadable count. Also the reset value of count and of the reload value.
//   W            Count width. Derived from MAX+1 so that power-of-two MAX values fit.
//   TICK_DIV     Clock cycles per decrement when PRESCALE_EN is defined (>= 1).
//
// Ports:
//   CLOCK_50     System clock. All logic runs on the rising edge.
//   reset        Synchronous, active-high reset.
//   load         Loads clamp(load_value) into count and reload; returns to IDLE.
//                Has the highest priority after reset.
//   load_value   Value to load. Values above MAX are clamped to MAX.
//   start        Starts counting from IDLE, or restarts from reload in EXPIRED.
//   pause        Level input. Freezes counting while high in RUN or PAUSED.
//   auto_reload  1 selects periodic mode, 0 selects one-shot mode. Sampled on every tick.
//   count        Current count (registered).
//   running      High in RUN (registered).
//   paused       High in PAUSED (registered).
//   done         One-cycle pulse at each expiry or period end (registered).
//   expired      Sticky flag; high in EXPIRED (registered).

module countdown_timer #(
    parameter int unsigned MAX      = 50000000,
    parameter int unsigned W        = $clog2(MAX + 1),
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         start,
    input  logic         pause,
    input  logic         auto_reload,
    output logic [W-1:0] count,
    output logic         running,
    output logic         paused,
    output logic         done,
    output logic         expired
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPaused,
        StExpired
    } state_e;

    localparam logic [W-1:0] MaxCount = W'(MAX);
    localparam logic [W-1:0] OneCount = W'(1);

    state_e       state_q;
    logic [W-1:0] reload_q;
    logic [W-1:0] load_clamped;
    logic         tick;

    assign load_clamped = (load_value > MaxCount) ? MaxCount : load_value;

`ifdef PRESCALE_EN
    // Guard the width for TICK_DIV == 1. In that case the prescaler stays at 0 and ticks
    // every cycle.
    localparam int unsigned    PreW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);

    logic [PreW-1:0] prescale_q;

    assign tick = (prescale_q == PreLast);

    // The prescaler advances only on RUN cycles that are not paused. It is frozen in PAUSED,
    // so a pause/resume does not lose the partial period. It restarts on every start, so the
    // first decrement lands TICK_DIV cycles after entering RUN.
    always_ff @(posedge CLOCK_50) begin
        if (reset || load) begin
            prescale_q <= '0;
        end else if (state_q == StRun && !pause) begin
            prescale_q <= tick ? '0 : prescale_q + PreW'(1);
        end else if (start && (state_q == StIdle || state_q == StExpired)) begin
            prescale_q <= '0;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // Next-state and registered outputs are updated together. Each status flag changes in the
    // same cycle as the state change that implies it.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= StIdle;
            count    <= MaxCount;
            reload_q <= MaxCount;
            running  <= 1'b0;
            paused   <= 1'b0;
            done     <= 1'b0;
            expired  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                // Aborts any activity without a done pulse.
                state_q  <= StIdle;
                count    <= load_clamped;
                reload_q <= load_clamped;
                running  <= 1'b0;
                paused   <= 1'b0;
                expired  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        // pause has no effect in IDLE; only start matters here.
                        if (start) begin
                            state_q <= StRun;
                            running <= 1'b1;
                        end
                    end

                    StExpired: begin
                        if (start) begin
                            state_q <= StRun;
                            count   <= reload_q;
                            running <= 1'b1;
                            expired <= 1'b0;
                        end
                    end

                    StPaused: begin
                        if (!pause) begin
                            state_q <= StRun;
                            running <= 1'b1;
                            paused  <= 1'b0;
                        end
                    end

                    StRun: begin
                        if (pause) begin
                            state_q <= StPaused;
                            running <= 1'b0;
                            paused  <= 1'b1;
                        end else if (tick) begin
                            if (count > OneCount) begin
                                count <= count - OneCount;
                            end else if (count == OneCount && auto_reload) begin
                                // Period end: reload and keep running.
                                count <= reload_q;
                                done  <= 1'b1;
                            end else begin
                                // Reached 0 in one-shot mode, or was started at 0 in
                                // either mode.
                                state_q <= StExpired;
                                count   <= '0;
                                done    <= 1'b1;
                                running <= 1'b0;
                                expired <= 1'b1;
                            end
                        end
                    end

                    default: begin
                        state_q <= StIdle;
                        running <= 1'b0;
                        paused  <= 1'b0;
                        expired <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Testbench for countdown_timer.
// A driver applies one input vector per cycle and pushes the expected outputs to a queue.
// The expected outputs come from a reference model of the timer rules.
// A monitor compares the DUT outputs against the queue after each clock edge.

module tb_countdown_timer;

    localparam int unsigned MAX   = 10;
    localparam int unsigned W     = $clog2(MAX + 1);
    localparam int unsigned TD    = 4;
    localparam int unsigned NRAND = 3000;

    typedef logic [W+3:0] obs_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_value = '0;
    logic         start = 1'b0;
    logic         pause = 1'b0;
    logic         auto_reload = 1'b0;
    logic [W-1:0] count;
    logic         running;
    logic         paused;
    logic         done;
    logic         expired;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_no = 0;

    // Reference model state.
    localparam int ModeIdle    = 0;
    localparam int ModeRun     = 1;
    localparam int ModePaused  = 2;
    localparam int ModeExpired = 3;

    int m_mode;
    int m_count;
    int m_reload;
    int m_elapsed;  // RUN cycles since the last tick
    bit m_done;

    countdown_timer #(
        .MAX      (MAX),
        .TICK_DIV (TD)
    ) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .load        (load),
        .load_value  (load_value),
        .start       (start),
        .pause       (pause),
        .auto_reload (auto_reload),
        .count       (count),
        .running     (running),
        .paused      (paused),
        .done        (done),
        .expired     (expired)
    );

    always #5 clk = ~clk;

    function automatic bit model_tick();
`ifdef PRESCALE_EN
        m_elapsed = m_elapsed + 1;
        if (m_elapsed == TD) begin
            m_elapsed = 0;
            return 1'b1;
        end
        return 1'b0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_step(input bit r, input bit l, input int lv, input bit s,
                              input bit p, input bit ar);
        m_done = 1'b0;
        if (r) begin
            m_mode = ModeIdle; m_count = MAX; m_reload = MAX; m_elapsed = 0;
        end else if (l) begin
            m_count   = (lv > MAX) ? MAX : lv;
            m_reload  = m_count;
            m_mode    = ModeIdle;
            m_elapsed = 0;
        end else if (m_mode == ModeIdle) begin
            if (s) begin m_mode = ModeRun; m_elapsed = 0; end
        end else if (m_mode == ModeExpired) begin
            if (s) begin m_mode = ModeRun; m_count = m_reload; m_elapsed = 0; end
        end else if (m_mode == ModePaused) begin
            if (!p) m_mode = ModeRun;
        end else if (p) begin
            m_mode = ModePaused;
        end else if (model_tick()) begin
            if (m_count >= 2) begin
                m_count = m_count - 1;
            end else begin
                m_done = 1'b1;
                if (m_count == 1 && ar) m_count = m_reload;
                else begin m_count = 0; m_mode = ModeExpired; end
            end
        end
    endtask

    task automatic cyc(input bit r, input bit l, input int lv, input bit s, input bit p,
                       input bit ar);
        obs_t e;
        @(negedge clk);
        reset = r; load = l; load_value = W'(lv); start = s; pause = p; auto_reload = ar;
        model_step(r, l, lv, s, p, ar);
        e = {W'(m_count), m_mode == ModeRun, m_mode == ModePaused, m_done,
             m_mode == ModeExpired};
        exp_q.push_back(e);
    endtask

    // Monitor: the outputs are registered, so they are compared once per cycle after the edge.
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clk);
            #2;
            cyc_no++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {count, running, paused, done, expired};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL cycle %0d outputs: got count=%0d run=%b pau=%b done=%b exp=%b, expected count=%0d run=%b pau=%b done=%b exp=%b",
                             cyc_no, a[W+3:4], a[3], a[2], a[1], a[0],
                             e[W+3:4], e[3], e[2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        bit p;
        bit ar;
        p  = 1'b0;
        ar = 1'b0;

        // Reset state.
        cyc(1, 0, 0, 0, 0, 0);
        // One-shot from 3, then restart from EXPIRED.
        cyc(0, 1, 3, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        repeat (16) cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0);
        // Periodic from 2.
        cyc(0, 1, 2, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 1);
        repeat (20) cyc(0, 0, 0, 0, 0, 1);
        // Pause with pause also asserted in IDLE.
        cyc(0, 1, 9, 0, 1, 0);
        cyc(0, 0, 0, 1, 0, 0);
        repeat (4) cyc(0, 0, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 1, 1, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0);
        // Clamp, then load mid-run, then load and start in the same cycle.
        cyc(0, 1, 15, 0, 0, 0);
        cyc(0, 1, 7, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 7, 0, 0, 0);
        cyc(0, 1, 5, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        // Started at 0: expires even in periodic mode.
        cyc(0, 1, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 1);
        repeat (6) cyc(0, 0, 0, 0, 0, 1);
        // Reset mid-run.
        cyc(0, 1, 6, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < NRAND; i++) begin
            if ($urandom_range(0, 39) == 0) ar = ~ar;
            if (!p && $urandom_range(0, 9) == 0) p = 1'b1;
            else if (p && $urandom_range(0, 2) == 0) p = 1'b0;
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 24) == 0,
                int'($urandom_range(0, 15)), $urandom_range(0, 5) == 0, p, ar);
        end

        // Bounded drain of the remaining expectations.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
